mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - state_t   : arbiter FSM states
//   - req_id_t  : requester identifiers (IF=0, DAT=1, LD=2). These values are
//                 also the bit positions in the packed request/grant vectors.
//   - ADDR_W_DEF / DATA_W_DEF : default memory address / data widths
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int N_REQ      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ID_IF  = 2'd0,
    ID_DAT = 2'd1,
    ID_LD  = 2'd2
  } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Ports:
//   req       in  [2:0] pending requests, indexed by req_id_t
//   last_dat  in  1     round-robin pointer: 1 = dat was granted last
//   win_id    out       selected requester
//   win_valid out 1     at least one request is pending
// The loader always wins. Between if and dat the one not granted last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last_dat,
  output req_id_t          win_id,
  output logic             win_valid
);

  always_comb begin
    win_valid = |req;
    win_id    = ID_IF;
    if (req[ID_LD]) begin
      win_id = ID_LD;
    end else if (req[ID_IF] && req[ID_DAT]) begin
      win_id = last_dat ? ID_IF : ID_DAT;
    end else if (req[ID_DAT]) begin
      win_id = ID_DAT;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for a single-port synchronous memory.
// Requesters: if (instruction fetch), dat (load/store data), ld (loader).
// Ports:
//   CLK, Reset (active-low, asynchronous)
//   <r>_req/_we/_addr/_wdata in : request held until <r>_gnt
//   <r>_gnt, <r>_rvalid      out : one-cycle pulses
//   <r>_rdata                out : last read response (shared register)
//   mem_en/_we/_addr/_wdata  out : memory command, valid during ISSUE only
//   mem_rdata                in  : valid RD_LAT cycles after mem_en
//   busy                     out : FSM is not IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              if_req,
  input  logic              if_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] if_wdata,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dat_req,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  output logic              dat_gnt,
  output logic              dat_rvalid,
  output logic [DATA_W-1:0] dat_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Final RDWAIT count value; the memory data is captured in that cycle.
  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

  logic [N_REQ-1:0]  req_vec, we_vec, gnt_vec, rvalid_vec;
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  req_id_t           win_id, win_id_reg;
  logic              win_valid;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              last_dat_reg;
  logic              arb_load, rd_capture;

  assign req_vec      = {ld_req, dat_req, if_req};
  assign we_vec       = {ld_we, dat_we, if_we};
  assign addr_arr[0]  = if_addr;
  assign addr_arr[1]  = dat_addr;
  assign addr_arr[2]  = ld_addr;
  assign wdata_arr[0] = if_wdata;
  assign wdata_arr[1] = dat_wdata;
  assign wdata_arr[2] = ld_wdata;

  mem_arb_pick u_pick (
    .req       (req_vec),
    .last_dat  (last_dat_reg),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    arb_load   = 1'b0;
    rd_capture = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) begin
          arb_load   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_reg) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RDWAIT;
          cnt_next   = 2'd0;
        end
      end
      ST_RDWAIT: begin
        if (cnt_reg == RD_LAST) begin
          rd_capture = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Winner attributes are latched on the edge leaving IDLE, so a requester
  // may change its inputs freely once it has been granted.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      win_id_reg   <= ID_IF;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      last_dat_reg <= 1'b1;
      rdata_reg    <= '0;
    end else begin
      if (arb_load) begin
        win_id_reg <= win_id;
        we_reg     <= we_vec[win_id];
        addr_reg   <= addr_arr[win_id];
        wdata_reg  <= wdata_arr[win_id];
        // Loader grants leave the if/dat rotation untouched.
        if (win_id != ID_LD) begin
          last_dat_reg <= (win_id == ID_DAT);
        end
      end
      if (rd_capture) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
      assign gnt_vec[gi]    = (state_reg == ST_ISSUE) && (win_id_reg == 2'(gi));
      assign rvalid_vec[gi] = (state_reg == ST_RESP)  && (win_id_reg == 2'(gi));
    end
  endgenerate

  assign if_gnt     = gnt_vec[0];
  assign dat_gnt    = gnt_vec[1];
  assign ld_gnt     = gnt_vec[2];
  assign if_rvalid  = rvalid_vec[0];
  assign dat_rvalid = rvalid_vec[1];
  assign ld_rvalid  = rvalid_vec[2];
  assign if_rdata   = rdata_reg;
  assign dat_rdata  = rdata_reg;
  assign ld_rdata   = rdata_reg;

  assign mem_en    = (state_reg == ST_ISSUE);
  assign mem_we    = mem_en && we_reg;
  assign mem_addr  = mem_en ? addr_reg : '0;
  assign mem_wdata = mem_we ? wdata_reg : '0;
  assign busy      = (state_reg != ST_IDLE);

endmodule
